// File: rtl/trace_pkg.sv
// Shared types for the retire trace monitor: FSM states, trace entry layout
// and register-address width.
package trace_pkg;
  localparam int REGADDR_W = 5;
  localparam int DEF_XLEN  = 32;
  localparam int DEF_CYC_W = 16;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} mon_state_t;

  typedef struct packed {
    logic [REGADDR_W-1:0] rd;
    logic [DEF_XLEN-1:0]  data;
    logic [DEF_CYC_W-1:0] cycle;
  } trace_entry_t;
endpackage

// File: rtl/retire_trace_monitor_if.sv
// Trace drain port: valid/ready handshake carrying the FIFO head entry.
interface retire_trace_monitor_if
  import trace_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CYC_W = 16
);
  logic                 trace_valid;
  logic                 trace_ready;
  logic [REGADDR_W-1:0] trace_rd;
  logic [XLEN-1:0]      trace_data;
  logic [CYC_W-1:0]     trace_cycle;

  modport master (output trace_valid, trace_rd, trace_data, trace_cycle,
                  input  trace_ready);
  modport slave  (input  trace_valid, trace_rd, trace_data, trace_cycle,
                  output trace_ready);
endinterface

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO for trace entries; extra pointer MSB
// distinguishes full from empty. Head reads as zero while empty.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int  DEPTH = 16,
  parameter type T     = trace_entry_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  output logic full,
  output logic empty,
  input  T     din,
  output T     dout
);
  localparam int AW = $clog2(DEPTH);

  T             mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/retire_trace_monitor.sv
// Run monitor beside the core: traces register write-backs into a FIFO,
// counts cycles/retirements and ends a run on PC halt or cycle timeout.
module retire_trace_monitor
  import trace_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int FIFO_DEPTH  = 16,
  parameter int CYC_W       = 16,
  parameter int MAX_CYCLES  = 30,
  parameter int HALT_REPEAT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [XLEN-1:0]        pc_in,
  input  logic                   wb_en,
  input  logic [REGADDR_W-1:0]   wb_rd,
  input  logic [XLEN-1:0]        wb_data,
  retire_trace_monitor_if.master trace,
  output logic                   running,
  output logic                   done,
  output logic                   halted,
  output logic                   timeout,
  output logic [CYC_W-1:0]       cycle_count,
  output logic [CYC_W-1:0]       retire_count,
  output logic [CYC_W-1:0]       dropped
);
  localparam int SW = $clog2(HALT_REPEAT + 1);

  typedef struct packed {
    logic [REGADDR_W-1:0] rd;
    logic [XLEN-1:0]      data;
    logic [CYC_W-1:0]     cycle;
  } entry_t;

  mon_state_t      state, state_nxt;
  logic [XLEN-1:0] prev_pc;
  logic [SW-1:0]   stable_cnt;
  logic            fifo_full, fifo_empty;
  logic            pop, push, qual, start_run, pc_eq, halt_hit, to_hit;
  entry_t          din, dout;

  assign start_run = ((state == IDLE) || (state == DONE)) && start;
  assign qual      = (state == RUN) && wb_en && (wb_rd != '0);
  assign pop       = !fifo_empty && trace.trace_ready;
  assign push      = qual && (!fifo_full || pop);
  assign pc_eq     = (pc_in == prev_pc);
  // stable_cnt holds equal comparisons seen so far; this cycle's match is the last one needed
  assign halt_hit  = (state == RUN) && pc_eq && (stable_cnt == SW'(HALT_REPEAT - 2));
  assign to_hit    = (state == RUN) && (cycle_count == CYC_W'(MAX_CYCLES - 1));
  assign din       = '{rd: wb_rd, data: wb_data, cycle: cycle_count};

  trace_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .din   (din),
    .dout  (dout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (start) state_nxt = RUN;
      RUN:        if (halt_hit || to_hit) state_nxt = DRAIN;
      DRAIN:      if (fifo_empty) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count  <= '0;
      retire_count <= '0;
      dropped      <= '0;
      stable_cnt   <= '0;
      halted       <= 1'b0;
      timeout      <= 1'b0;
    end else if (start_run) begin
      cycle_count  <= '0;
      retire_count <= '0;
      dropped      <= '0;
      stable_cnt   <= '0;
      halted       <= 1'b0;
      timeout      <= 1'b0;
    end else if (state == RUN) begin
      if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
      if (qual && (retire_count != '1)) retire_count <= retire_count + 1'b1;
      if (qual && fifo_full && !pop && (dropped != '1)) dropped <= dropped + 1'b1;
      stable_cnt <= pc_eq ? stable_cnt + 1'b1 : '0;
      if (halt_hit) halted  <= 1'b1;
      if (to_hit)   timeout <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_pc <= '0;
    else        prev_pc <= pc_in;
  end

  assign running           = (state == RUN);
  assign done              = (state == DONE);
  assign trace.trace_valid = !fifo_empty;
  assign trace.trace_rd    = dout.rd;
  assign trace.trace_data  = dout.data;
  assign trace.trace_cycle = dout.cycle;
endmodule
